// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: store op encodings, store FSM states and lane widths.
package mips_defs_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      ST_SW  = 2'd0,
      ST_SH  = 2'd1,
      ST_SB  = 2'd2,
      ST_RSV = 2'd3
   } store_op_t;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWait,
      StWr,
      StFin
   } store_state_t;

endpackage

// File: rtl/store_pack_if.sv
// Store request handshake and data-memory port of the store packer.
// master: the requester plus memory side; slave: the store packer itself.
interface store_pack_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_addr;
   logic [31:0]       req_data;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [31:0]       mem_rdata;
   logic              mem_wr_en;
   logic [31:0]       mem_wdata;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_addr, req_data, req_op, mem_rdata,
      input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_op, mem_rdata,
      output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
   );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the narrow store data into the addressed
// little-endian lane of the read-back word; other lanes keep the old value.
module store_lane_merge
   import mips_defs_pkg::*;
(
   input  logic [WORD_W-1:0] old_word,
   input  logic [WORD_W-1:0] data,
   input  store_op_t         op,
   input  logic [1:0]        addr_lo,
   output logic [WORD_W-1:0] merged
);

   // Replace only the selected lane; SH uses addr_lo[1] alone
   always_comb begin
      merged = old_word;
      unique case (op)
         ST_SW:   merged = data;
         ST_SH:   merged[addr_lo[1]*HALF_W +: HALF_W] = data[HALF_W-1:0];
         ST_SB:   merged[addr_lo*BYTE_W +: BYTE_W] = data[BYTE_W-1:0];
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/store_pack.sv
// Store-side data packer: narrows a register value into the addressed lanes of a
// word-addressed single-port memory, using read-modify-write for SH/SB.
// Optional build macro: STORE_ALIGN_CHECK_EN (flags misaligned SW/SH via err).
module store_pack
   import mips_defs_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   store_pack_if.slave  bus
);

   store_state_t      state_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       data_q;
   store_op_t         op_q;
   logic [31:0]       old_q;
   logic              ready_q;
   logic              rd_q;
   logic              wr_q;
   logic              done_q;
   logic              err_q;
   logic              misalign;
   logic              wr_en;
   logic [31:0]       merged;
   store_op_t         req_op;

   assign req_op = store_op_t'(bus.req_op);

   // Misalignment is only detected in the checked build
`ifdef STORE_ALIGN_CHECK_EN
   assign misalign = ((req_op == ST_SW) && (bus.req_addr[1:0] != 2'b00)) ||
                     ((req_op == ST_SH) && bus.req_addr[0]);
`else
   assign misalign = 1'b0;
`endif

   // Store sequencer: latches the request and drives registered strobes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         data_q  <= '0;
         op_q    <= ST_SW;
         old_q   <= '0;
         ready_q <= 1'b1;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  addr_q  <= bus.req_addr[ADDR_W+1:0];
                  data_q  <= bus.req_data;
                  op_q    <= req_op;
                  ready_q <= 1'b0;
                  if (misalign) begin
                     state_q <= StFin;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     case (req_op)
                        ST_SW: begin
                           state_q <= StWr;
                           wr_q    <= 1'b1;
                           done_q  <= 1'b1;
                        end
                        ST_SH, ST_SB: begin
                           state_q <= StRd;
                           rd_q    <= 1'b1;
                        end
                        default: begin
                           state_q <= StFin;
                           done_q  <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            StRd: begin
               state_q <= StWait;
            end
            StWait: begin
               // Read data arrives the cycle after the read strobe
               old_q   <= bus.mem_rdata;
               state_q <= StWr;
               wr_q    <= 1'b1;
               done_q  <= 1'b1;
            end
            StWr, StFin: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   store_lane_merge u_merge (
      .old_word (old_q),
      .data     (data_q),
      .op       (op_q),
      .addr_lo  (addr_q[1:0]),
      .merged   (merged)
   );

   // Strobes are forced low while reset is held so an in-flight store never lands
   assign wr_en         = wr_q & reset_n;
   assign bus.req_ready = ready_q;
   assign bus.mem_addr  = addr_q[ADDR_W+1:2];
   assign bus.mem_rd_en = rd_q & reset_n;
   assign bus.mem_wr_en = wr_en;
   assign bus.mem_wdata = wr_en ? merged : '0;
   assign bus.done      = done_q & reset_n;
   assign bus.err       = err_q & reset_n;

endmodule

// File: tb/tb_store_pack.sv
// Directed bench for store_pack with a synchronous memory model and a write scoreboard.
`timescale 1ns/1ps
module tb_store_pack;
   import mips_defs_pkg::*;

   localparam int unsigned ADDR_W = 10;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] mem [0:1023];
   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          r0;
   int          w0;
   logic [31:0] word4_exp;

   store_pack_if #(.ADDR_W(ADDR_W)) bus ();

   store_pack #(.ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Single-port synchronous memory: read data valid one cycle after mem_rd_en
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every memory write must match the oldest expected write
   always @(negedge clk) begin
      if (bus.mem_rd_en === 1'b1) rd_cnt++;
      if (bus.mem_wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected_write observed addr=0x%0h data=0x%08h expected none",
                   bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("sb_addr", 32'(bus.mem_addr), e.addr);
            chk("sb_data", bus.mem_wdata, e.data);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_data  = d;
      bus.req_op    = op;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_op    = '0;
      reset_n       = 1'b0;

      // Reset state
      step();
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rd", 32'(bus.mem_rd_en), 32'd0);
      chk("rst_wr", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // SW preload of word 4: write at +1, no read
      r0 = rd_cnt;
      drive(32'h10, 32'h11223344, ST_SW);
      push(32'd4, 32'h11223344);
      step();
      bus.req_valid = 1'b0;
      chk("swpre_wr", 32'(bus.mem_wr_en), 32'd1);
      chk("swpre_done", 32'(bus.done), 32'd1);
      chk("swpre_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("swpre_ready_back", 32'(bus.req_ready), 32'd1);
      chk("swpre_no_rd", 32'(rd_cnt - r0), 32'd0);

      // SB addr 0x11: read at +1, write/done at +3
      drive(32'h11, 32'hFFFFFFAB, ST_SB);
      push(32'd4, 32'h1122AB44);
      step();
      bus.req_valid = 1'b0;
      chk("sb_rd_p1", 32'(bus.mem_rd_en), 32'd1);
      chk("sb_wr_p1", 32'(bus.mem_wr_en), 32'd0);
      chk("sb_addr_p1", 32'(bus.mem_addr), 32'd4);
      step();
      chk("sb_rd_p2", 32'(bus.mem_rd_en), 32'd0);
      chk("sb_done_p2", 32'(bus.done), 32'd0);
      step();
      chk("sb_wr_p3", 32'(bus.mem_wr_en), 32'd1);
      chk("sb_done_p3", 32'(bus.done), 32'd1);
      chk("sb_wdata_p3", bus.mem_wdata, 32'h1122AB44);
      step();
      chk("sb_ready_p4", 32'(bus.req_ready), 32'd1);

      // Restore preload, then SH addr 0x12 writes upper half only
      drive(32'h10, 32'h11223344, ST_SW);
      push(32'd4, 32'h11223344);
      step();
      bus.req_valid = 1'b0;
      step();
      w0 = wr_cnt;
      drive(32'h12, 32'h0000BEEF, ST_SH);
      push(32'd4, 32'hBEEF3344);
      step();
      bus.req_valid = 1'b0;
      chk("sh_wr_p1", 32'(bus.mem_wr_en), 32'd0);
      step();
      chk("sh_wr_p2", 32'(bus.mem_wr_en), 32'd0);
      step();
      chk("sh_wr_p3", 32'(bus.mem_wr_en), 32'd1);
      chk("sh_wdata_p3", bus.mem_wdata, 32'hBEEF3344);
      step();
      chk("sh_wr_count", 32'(wr_cnt - w0), 32'd1);

      // SW addr 0x20: write at +1 to word 8, never reads
      r0 = rd_cnt;
      drive(32'h20, 32'hDEADBEEF, ST_SW);
      push(32'd8, 32'hDEADBEEF);
      step();
      bus.req_valid = 1'b0;
      chk("sw_wr_p1", 32'(bus.mem_wr_en), 32'd1);
      chk("sw_addr_p1", 32'(bus.mem_addr), 32'd8);
      chk("sw_wdata_p1", bus.mem_wdata, 32'hDEADBEEF);
      step();
      chk("sw_no_rd", 32'(rd_cnt - r0), 32'd0);

      // SH addr 0x13: misaligned in the checked build
      r0 = rd_cnt;
      w0 = wr_cnt;
      drive(32'h13, 32'h0000CAFE, ST_SH);
`ifdef STORE_ALIGN_CHECK_EN
      word4_exp = 32'hBEEF3344;
      step();
      bus.req_valid = 1'b0;
      chk("mis_err_p1", 32'(bus.err), 32'd1);
      chk("mis_done_p1", 32'(bus.done), 32'd1);
      step();
      chk("mis_err_p2", 32'(bus.err), 32'd0);
      chk("mis_no_mem", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
`else
      word4_exp = 32'hCAFE3344;
      push(32'd4, 32'hCAFE3344);
      step();
      bus.req_valid = 1'b0;
      chk("sh13_rd_p1", 32'(bus.mem_rd_en), 32'd1);
      chk("sh13_err_p1", 32'(bus.err), 32'd0);
      step(2);
      chk("sh13_wr_p3", 32'(bus.mem_wr_en), 32'd1);
      chk("sh13_err_p3", 32'(bus.err), 32'd0);
      step();
      chk("sh13_wr_count", 32'(wr_cnt - w0), 32'd1);
`endif
      step();

      // SB aborted by reset during WAIT: nothing written
      drive(32'h10, 32'h00000055, ST_SB);
      step();
      bus.req_valid = 1'b0;
      chk("abort_rd_p1", 32'(bus.mem_rd_en), 32'd1);
      step();
      reset_n = 1'b0;
      #1;
      chk("abort_wr_rst", 32'(bus.mem_wr_en), 32'd0);
      chk("abort_done_rst", 32'(bus.done), 32'd0);
      step();
      chk("abort_wr_p3", 32'(bus.mem_wr_en), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      reset_n = 1'b1;
      step(2);
      chk("abort_word4", mem[4], word4_exp);

      // Two SB requests with req_valid held high
      drive(32'h20, 32'h00000077, ST_SB);
      push(32'd8, 32'hDEADBE77);
      push(32'd8, 32'h66ADBE77);
      step();
      drive(32'h23, 32'h00000066, ST_SB);
      chk("b2b_ready_p1", 32'(bus.req_ready), 32'd0);
      step();
      chk("b2b_ready_p2", 32'(bus.req_ready), 32'd0);
      step();
      chk("b2b_ready_p3", 32'(bus.req_ready), 32'd0);
      chk("b2b_wdata1", bus.mem_wdata, 32'hDEADBE77);
      step();
      chk("b2b_ready_p4", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      chk("b2b_rd2", 32'(bus.mem_rd_en), 32'd1);
      step(2);
      chk("b2b_wr2", 32'(bus.mem_wr_en), 32'd1);
      chk("b2b_wdata2", bus.mem_wdata, 32'h66ADBE77);
      step();

      // Reserved op: done at +1, no memory access, err low
      r0 = rd_cnt;
      w0 = wr_cnt;
      drive(32'h10, 32'h12345678, ST_RSV);
      step();
      bus.req_valid = 1'b0;
      chk("rsv_done_p1", 32'(bus.done), 32'd1);
      chk("rsv_err_p1", 32'(bus.err), 32'd0);
      step();
      chk("rsv_ready_p2", 32'(bus.req_ready), 32'd1);
      chk("rsv_no_mem", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);

      step(2);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      chk("final_word4", mem[4], word4_exp);
      chk("final_word8", mem[8], 32'h66ADBE77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
